sva_until_checker_mt: RTL and testbench
=======================================

// Module: sva_until_checker_mt
// PURPOSE
//  Multi-thread checker for "(!a && !b)[*0:MAX_WAIT-1] ##0 b": on every sample a new attempt
//  starts; each live attempt passes on b, keeps waiting on !a && !b, fails on a && !b or timeout.
//  Next generation of the single-thread SVA FSM checkers: parametrised thread pool, bounded wait,
//  start stamps, saturating counters. Single sys_clk domain; user clock edges arrive as sample_en.
// PARAMETERS
//  NUM_THREADS  4   max live attempts kept in the pool (>=1)
//  AGE_WIDTH    8   width of per-thread age and of the sample stamp counter
//  MAX_WAIT     16  samples an attempt may wait; 0 = unbounded (no timeout)
//  CNT_WIDTH    16  width of succ_cnt / fail_cnt
// PORTS
//  sys_clk        in   1                  clock
//  sys_rst_n      in   1                  reset, asynchronous, active-low
//  sample_en      in   1                  one-cycle pulse: sample a/b (user clock edge)
//  check_en       in   1                  spawn a new attempt on this sample
//  a, b           in   1                  property inputs, valid when sample_en=1
//  busy           out  1                  evaluation in progress (ctrl state != IDLE)
//  succ           out  1                  pulse: one attempt passed
//  fail           out  1                  pulse: one attempt failed (a before b, or timeout)
//  timeout        out  1                  pulse, with fail: failure cause is timeout
//  res_stamp      out  AGE_WIDTH          start stamp of the attempt resolved this cycle
//  overflow       out  1                  sticky: new attempt dropped, pool full
//  overrun        out  1                  sticky: sample_en arrived while busy
//  live_cnt       out  $clog2(NUM_THREADS+1) live attempts after last evaluation
//  succ_cnt       out  CNT_WIDTH          saturating pass count
//  fail_cnt       out  CNT_WIDTH          saturating fail count
// BEHAVIOUR
//  Reset: all outputs 0, pool empty, stamp counter 0, state IDLE; async clear mid-eval drops all.
//  Control FSM IDLE -> EVAL -> SPAWN -> IDLE:
//   IDLE : on sample_en latch a_q,b_q, stamp++ (wraps), rd_idx=wr_idx=0, go EVAL.
//   EVAL : one thread/cycle, rd_idx 0..live_cnt-1 (unrolled into one cycle when live_cnt=0).
//          Survivor written to slot wr_idx, wr_idx++ (pool compacts in order, oldest first).
//          When rd_idx==live_cnt go SPAWN.
//   SPAWN: if check_en_q, evaluate new thread {state S0, age 0, stamp}; survivor stored at wr_idx
//          if wr_idx<NUM_THREADS else dropped and overflow set. live_cnt<=final wr_idx. -> IDLE.
//  Step rule (S0 and S1 identical): b_q -> pass; !a_q&&!b_q -> age+1, if MAX_WAIT!=0 and
//   age+1==MAX_WAIT -> fail+timeout else state S1; a_q&&!b_q -> fail.
//  Result pulses registered, one per evaluated thread, same cycle as res_stamp; at most one/cycle.
//  Latency: sample_en -> last result pulse = live_cnt+2 cycles; busy high for live_cnt+2 cycles.
//  sample_en while busy: ignored, overrun set; overflow/overrun clear only on reset.
//  Counters saturate at all-ones; age never exceeds MAX_WAIT; stamp wraps modulo 2^AGE_WIDTH.
// STRUCTURE
//  Package sva_chk_pkg: sva_fsm_t (int enum S0=0, SEND=-1, SLAZY=-2, S1=1), sva_res_t
//   {RES_WAIT, RES_PASS, RES_FAIL, RES_TIMEOUT}, ctrl_fsm_t {IDLE, EVAL, SPAWN}.
//  Thread record (active, stamp, age, fsm_cur) is a local packed struct (parameter widths).
//  Sub-module sva_until_step: combinational step rule, record+a_q+b_q -> next record + sva_res_t.
// TESTING
//  T1 check_en=1, sample a=0,b=1 -> next result cycle succ=1, res_stamp=1, live_cnt=0, succ_cnt=1.
//  T2 samples (a,b)=(0,0),(0,0),(0,1) -> live_cnt 1,2 then on 3rd sample 3 succ pulses
//     (stamps 1,2,3), live_cnt=0.
//  T3 MAX_WAIT=3, check_en only on 1st sample, then (0,0) x3 -> 3rd sample fail=timeout=1,
//     res_stamp=1, fail_cnt=1.
//  T4 NUM_THREADS=4, five (0,0) samples -> 5th sample overflow=1, live_cnt=4, no fail pulse.
//  T5 sample_en on two consecutive cycles with live_cnt=2 -> overrun=1, stamp advanced once.
//  T6 sys_rst_n low during EVAL with live_cnt=3 -> busy=0, live_cnt=0, counters 0 immediately.

Source files
------------

// File: rtl/sva_chk_pkg.sv
// Shared types for the multi-thread until checker: property thread state,
// per-step verdict and the control sequencer states.
package sva_chk_pkg;

  typedef enum int {
    S0    = 0,
    SEND  = -1,
    SLAZY = -2,
    S1    = 1
  } sva_fsm_t;

  typedef enum logic [1:0] {
    RES_WAIT,
    RES_PASS,
    RES_FAIL,
    RES_TIMEOUT
  } sva_res_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SPAWN
  } ctrl_fsm_t;

endpackage

// File: rtl/sva_until_step.sv
// One evaluation step of a single "(!a && !b)[*0:MAX_WAIT-1] ##0 b" attempt.
// Purely combinational: current thread record plus sampled a/b -> next record and verdict.
module sva_until_step
  import sva_chk_pkg::*;
#(
  parameter int AGE_WIDTH = 8,
  parameter int MAX_WAIT  = 16
) (
  input  logic     i_a_q,
  input  logic     i_b_q,
  input  logic [2*AGE_WIDTH+32:0] i_rec,
  output logic [2*AGE_WIDTH+32:0] o_rec,
  output sva_res_t o_res
);

  typedef struct packed {
    logic                 active;
    logic [AGE_WIDTH-1:0] stamp;
    logic [AGE_WIDTH-1:0] age;
    sva_fsm_t             fsm_cur;
  } thr_t;

  localparam logic [AGE_WIDTH:0] MW = (AGE_WIDTH + 1)'(MAX_WAIT);

  thr_t               w_cur;
  thr_t               w_nxt;
  logic [AGE_WIDTH:0] w_age_p1;

  assign w_cur = thr_t'(i_rec);
  assign o_rec = w_nxt;

  always_comb begin
    w_nxt    = w_cur;
    o_res    = RES_WAIT;
    w_age_p1 = {1'b0, w_cur.age} + (AGE_WIDTH + 1)'(1);
    if (w_cur.active) begin
      if (i_b_q) begin
        o_res         = RES_PASS;
        w_nxt.active  = 1'b0;
        w_nxt.fsm_cur = SEND;
      end else if (i_a_q) begin
        o_res         = RES_FAIL;
        w_nxt.active  = 1'b0;
        w_nxt.fsm_cur = SEND;
      end else begin
        // unbounded mode saturates instead of wrapping the age
        w_nxt.age = w_age_p1[AGE_WIDTH] ? w_cur.age : w_age_p1[AGE_WIDTH-1:0];
        if (MAX_WAIT != 0 && w_age_p1 == MW) begin
          o_res         = RES_TIMEOUT;
          w_nxt.active  = 1'b0;
          w_nxt.fsm_cur = SEND;
        end else begin
          w_nxt.fsm_cur = S1;
        end
      end
    end
  end

endmodule

// File: rtl/sva_until_checker_mt.sv
// Thread-pool checker: each sample steps every live attempt (oldest first, one per cycle),
// then optionally spawns a new one; the pool compacts in place as attempts resolve.
module sva_until_checker_mt
  import sva_chk_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int AGE_WIDTH   = 8,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                               i_sys_clk,
  input  logic                               i_sys_rst_n,
  input  logic                               i_sample_en,
  input  logic                               i_check_en,
  input  logic                               i_a,
  input  logic                               i_b,
  output logic                               o_busy,
  output logic                               o_succ,
  output logic                               o_fail,
  output logic                               o_timeout,
  output logic [AGE_WIDTH-1:0]               o_res_stamp,
  output logic                               o_overflow,
  output logic                               o_overrun,
  output logic [$clog2(NUM_THREADS+1)-1:0]   o_live_cnt,
  output logic [CNT_WIDTH-1:0]               o_succ_cnt,
  output logic [CNT_WIDTH-1:0]               o_fail_cnt
);

  localparam int CW = $clog2(NUM_THREADS + 1);
  localparam int SW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int PD = 2 ** SW;
  localparam logic [CW-1:0] NT = CW'(NUM_THREADS);

  typedef struct packed {
    logic                 active;
    logic [AGE_WIDTH-1:0] stamp;
    logic [AGE_WIDTH-1:0] age;
    sva_fsm_t             fsm_cur;
  } thr_t;

  ctrl_fsm_t            r_state, w_state_nxt;
  thr_t                 r_pool [PD];
  logic [CW-1:0]        r_rd_idx, r_wr_idx, r_live_cnt;
  logic                 r_a_q, r_b_q, r_chk_q;
  logic [AGE_WIDTH-1:0] r_stamp, r_res_stamp;
  logic                 r_succ, r_fail, r_timeout, r_overflow, r_overrun;
  logic [CNT_WIDTH-1:0] r_succ_cnt, r_fail_cnt;

  thr_t                 w_new, w_step_in, w_step_out;
  sva_res_t             w_res;
  logic                 w_eval_vld, w_room, w_keep;
  logic [CW-1:0]        w_wr_nxt;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_sample_en) w_state_nxt = EVAL;
      EVAL:    if (r_rd_idx == r_live_cnt) w_state_nxt = SPAWN;
      SPAWN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != IDLE);
  end

  // SPAWN steps a fresh attempt; EVAL steps the pool slot under rd_idx
  always_comb begin
    w_new         = '0;
    w_new.active  = 1'b1;
    w_new.stamp   = r_stamp;
    w_new.fsm_cur = S0;
    w_step_in     = (r_state == SPAWN) ? w_new : r_pool[r_rd_idx[SW-1:0]];
    w_eval_vld    = (r_state == EVAL && r_rd_idx != r_live_cnt) || (r_state == SPAWN && r_chk_q);
    w_room        = (r_wr_idx < NT);
  end

  sva_until_step #(
    .AGE_WIDTH (AGE_WIDTH),
    .MAX_WAIT  (MAX_WAIT)
  ) u_step (
    .i_a_q (r_a_q),
    .i_b_q (r_b_q),
    .i_rec (w_step_in),
    .o_rec (w_step_out),
    .o_res (w_res)
  );

  always_comb begin
    w_keep   = w_eval_vld && w_step_out.active && w_room;
    w_wr_nxt = w_keep ? r_wr_idx + CW'(1) : r_wr_idx;
  end

  always_ff @(posedge i_sys_clk) begin
    if (w_keep) r_pool[r_wr_idx[SW-1:0]] <= w_step_out;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_rd_idx    <= '0;
      r_wr_idx    <= '0;
      r_live_cnt  <= '0;
      r_a_q       <= 1'b0;
      r_b_q       <= 1'b0;
      r_chk_q     <= 1'b0;
      r_stamp     <= '0;
      r_res_stamp <= '0;
      r_succ      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_overrun   <= 1'b0;
      r_succ_cnt  <= '0;
      r_fail_cnt  <= '0;
    end else begin
      r_succ    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      if (i_sample_en) begin
        if (r_state == IDLE) begin
          r_a_q    <= i_a;
          r_b_q    <= i_b;
          r_chk_q  <= i_check_en;
          r_stamp  <= r_stamp + AGE_WIDTH'(1);
          r_rd_idx <= '0;
          r_wr_idx <= '0;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      if (r_state == EVAL && r_rd_idx != r_live_cnt) r_rd_idx <= r_rd_idx + CW'(1);
      if (w_eval_vld) begin
        r_wr_idx <= w_wr_nxt;
        if (w_step_out.active && !w_room) r_overflow <= 1'b1;
        if (w_res != RES_WAIT) r_res_stamp <= w_step_out.stamp;
        case (w_res)
          RES_PASS: begin
            r_succ <= 1'b1;
            if (r_succ_cnt != '1) r_succ_cnt <= r_succ_cnt + CNT_WIDTH'(1);
          end
          RES_FAIL, RES_TIMEOUT: begin
            r_fail    <= 1'b1;
            r_timeout <= (w_res == RES_TIMEOUT);
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_WIDTH'(1);
          end
          default: ;
        endcase
      end
      if (r_state == SPAWN) r_live_cnt <= w_wr_nxt;
    end
  end

  assign o_succ      = r_succ;
  assign o_fail      = r_fail;
  assign o_timeout   = r_timeout;
  assign o_res_stamp = r_res_stamp;
  assign o_overflow  = r_overflow;
  assign o_overrun   = r_overrun;
  assign o_live_cnt  = r_live_cnt;
  assign o_succ_cnt  = r_succ_cnt;
  assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_sva_until_checker_mt.sv
// Two checkers (MAX_WAIT 16 and 3) share one stimulus stream; a reference pool model
// queues the expected result pulses, a negedge monitor pops and compares them.
module tb_sva_until_checker_mt;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sample_en = 1'b0, check_en = 1'b0, a = 1'b0, b = 1'b0;

  logic        busy [2], succ [2], fail [2], tmo [2], ovf [2], ovr [2];
  logic [7:0]  rstamp [2];
  logic [2:0]  live [2];
  logic [15:0] sc [2], fc [2];

  int  n_chk = 0, n_err = 0;
  bit  mon_en = 1'b0;

  logic [10:0] q0 [$];
  logic [10:0] q1 [$];

  int         m_live [2], m_sc [2], m_fc [2];
  int         m_age [2][4];
  logic [7:0] m_stm [2][4];
  logic [7:0] m_stamp [2];
  bit         m_ovf [2], m_ovr [2];

  always #5 clk = ~clk;

  sva_until_checker_mt #(.NUM_THREADS(4), .AGE_WIDTH(8), .MAX_WAIT(16), .CNT_WIDTH(16)) u_dut16 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_sample_en(sample_en), .i_check_en(check_en),
    .i_a(a), .i_b(b), .o_busy(busy[0]), .o_succ(succ[0]), .o_fail(fail[0]),
    .o_timeout(tmo[0]), .o_res_stamp(rstamp[0]), .o_overflow(ovf[0]), .o_overrun(ovr[0]),
    .o_live_cnt(live[0]), .o_succ_cnt(sc[0]), .o_fail_cnt(fc[0]));

  sva_until_checker_mt #(.NUM_THREADS(4), .AGE_WIDTH(8), .MAX_WAIT(3), .CNT_WIDTH(16)) u_dut3 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_sample_en(sample_en), .i_check_en(check_en),
    .i_a(a), .i_b(b), .o_busy(busy[1]), .o_succ(succ[1]), .o_fail(fail[1]),
    .o_timeout(tmo[1]), .o_res_stamp(rstamp[1]), .o_overflow(ovf[1]), .o_overrun(ovr[1]),
    .o_live_cnt(live[1]), .o_succ_cnt(sc[1]), .o_fail_cnt(fc[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_live[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      m_stamp[k] = 8'd0; m_ovf[k] = 1'b0; m_ovr[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // kind: 001 pass, 100 fail, 110 timeout  ({fail, timeout, succ})
  task automatic push_ev(input int k, input logic [2:0] kind, input logic [7:0] st);
    if (kind[0]) m_sc[k]++;
    else         m_fc[k]++;
    if (k == 0) q0.push_back({kind, st});
    else        q1.push_back({kind, st});
  endtask

  task automatic step_thr(input int k, input int age, input logic [7:0] st,
                          input logic ai, input logic bi, input int mw, inout int w);
    if (bi)                           push_ev(k, 3'b001, st);
    else if (ai)                      push_ev(k, 3'b100, st);
    else if (mw != 0 && age + 1 == mw) push_ev(k, 3'b110, st);
    else if (w < 4) begin
      m_age[k][w] = age + 1;
      m_stm[k][w] = st;
      w++;
    end else m_ovf[k] = 1'b1;
  endtask

  task automatic model_sample(input int k, input logic ai, input logic bi, input logic ce);
    int w = 0;
    int mw = (k == 0) ? 16 : 3;
    m_stamp[k] = m_stamp[k] + 8'd1;
    for (int i = 0; i < m_live[k]; i++) step_thr(k, m_age[k][i], m_stm[k][i], ai, bi, mw, w);
    if (ce) step_thr(k, 0, m_stamp[k], ai, bi, mw, w);
    m_live[k] = w;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (succ[0] || fail[0] || tmo[0]) begin
        if (q0.size() == 0) check("unexp_res16", {21'd0, fail[0], tmo[0], succ[0], rstamp[0]}, 32'd0);
        else check("res16", {21'd0, fail[0], tmo[0], succ[0], rstamp[0]}, {21'd0, q0.pop_front()});
      end
      if (succ[1] || fail[1] || tmo[1]) begin
        if (q1.size() == 0) check("unexp_res3", {21'd0, fail[1], tmo[1], succ[1], rstamp[1]}, 32'd0);
        else check("res3", {21'd0, fail[1], tmo[1], succ[1], rstamp[1]}, {21'd0, q1.pop_front()});
      end
    end
  end

  task automatic check_state(input int k);
    check($sformatf("live%0d", k), 32'(live[k]), 32'(m_live[k]));
    check($sformatf("succ_cnt%0d", k), 32'(sc[k]), 32'(m_sc[k]));
    check($sformatf("fail_cnt%0d", k), 32'(fc[k]), 32'(m_fc[k]));
    check($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
    check($sformatf("overrun%0d", k), 32'(ovr[k]), 32'(m_ovr[k]));
  endtask

  // dbl holds sample_en one extra cycle so the second pulse lands while busy
  task automatic do_sample(input logic ai, input logic bi, input logic ce, input bit dbl);
    int lb0 = m_live[0], lb1 = m_live[1];
    int c0 = 0, c1 = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    a = ai; b = bi; check_en = ce; sample_en = 1'b1;
    model_sample(0, ai, bi, ce);
    model_sample(1, ai, bi, ce);
    if (dbl) begin m_ovr[0] = 1'b1; m_ovr[1] = 1'b1; end
    @(posedge clk); #1;
    sample_en = dbl;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c0 += int'(busy[0]);
      c1 += int'(busy[1]);
      if (!busy[0] && !busy[1]) begin done = 1'b1; break; end
      @(posedge clk); #1;
      sample_en = 1'b0;
    end
    if (!done) check("idle_timeout", 32'(busy[0] | busy[1]), 32'd0);
    check("busy_len16", 32'(c0), 32'(lb0 + 2));
    check("busy_len3", 32'(c1), 32'(lb1 + 2));
    check_state(0);
    check_state(1);
  endtask

  initial begin
    model_reset();
    #22;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_pulses", {29'd0, succ[k], fail[k], tmo[k]}, 32'd0);
      check("rst_stamp", 32'(rstamp[k]), 32'd0);
      check_state(k);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    do_sample(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) do_sample(1'b0, 1'b0, 1'b1, 1'b0);
    do_sample(1'b0, 1'b1, 1'b1, 1'b0);

    do_sample(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) do_sample(1'b0, 1'b0, 1'b0, 1'b0);
    do_sample(1'b0, 1'b1, 1'b0, 1'b0);

    do_sample(1'b1, 1'b0, 1'b1, 1'b0);
    do_sample(1'b1, 1'b1, 1'b1, 1'b0);

    repeat (5) do_sample(1'b0, 1'b0, 1'b1, 1'b0);
    do_sample(1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) do_sample(1'b0, 1'b0, 1'b1, 1'b0);
    do_sample(1'b0, 1'b1, 1'b0, 1'b1);
    do_sample(1'b0, 1'b1, 1'b1, 1'b0);

    @(posedge clk);
    check("q16_drained", 32'(q0.size()), 32'd0);
    check("q3_drained", 32'(q1.size()), 32'd0);

    repeat (3) do_sample(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    mon_en = 1'b0;
    #1;
    a = 1'b0; b = 1'b0; check_en = 1'b1; sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", 32'(busy[0]), 32'd0);
    check_state(0);
    check_state(1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    do_sample(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    check("q16_final", 32'(q0.size()), 32'd0);
    check("q3_final", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
